// File: rtl/data_frame_latch.sv
// data_frame_latch: start-armed capture of STAGE-word frames into a held,
// double-buffered valid/ready output bank. Define FRAME_TIMEOUT_EN for idle abort.
module data_frame_latch #(
  parameter int STAGE   = 8,
  parameter int DWIDTH  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] data,
  output logic [DWIDTH-1:0] data_q [0:STAGE-1],
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_done,
  output logic              busy,
  output logic              err_overrun,
  output logic              err_timeout
);

  localparam int IW = $clog2(STAGE);
  localparam logic [IW-1:0] LAST = IW'(STAGE - 1);

  if (STAGE < 2 || TIMEOUT < 1) begin : g_param_chk
    $error("data_frame_latch: needs STAGE >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    FULL
  } state_t;

  state_t state;
  state_t state_n;

  logic [IW-1:0]     idx;
  logic [DWIDTH-1:0] cap [0:STAGE-1];

  logic arm;
  logic take;
  logic slot_free;
  logic commit_cap;
  logic commit_full;
  logic abort;
  logic tmo_hit;

`ifdef FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tcnt;

  // Counts consecutive starved cycles; any word or leaving CAPTURE clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt <= '0;
    end else if (state != CAPTURE || in_valid) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  assign tmo_hit = (tcnt == TW'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n     = state;
    arm         = 1'b0;
    take        = 1'b0;
    commit_cap  = 1'b0;
    commit_full = 1'b0;
    abort       = 1'b0;
    slot_free   = !out_valid || out_ready;
    unique case (state)
      IDLE: begin
        if (start) begin
          arm     = 1'b1;
          state_n = CAPTURE;
        end
      end
      CAPTURE: begin
        if (in_valid) begin
          take = 1'b1;
          if (idx == LAST) begin
            // Bypass cap for the last word when the bank is free.
            if (slot_free) begin
              commit_cap = 1'b1;
              state_n    = IDLE;
            end else begin
              state_n = FULL;
            end
          end
        end else if (tmo_hit) begin
          abort   = 1'b1;
          state_n = IDLE;
        end
      end
      FULL: begin
        if (out_ready) begin
          commit_full = 1'b1;
          state_n     = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx         <= '0;
      out_valid   <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
      err_overrun <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      busy        <= (state_n != IDLE);
      frame_done  <= commit_cap | commit_full;
      err_overrun <= start && (state != IDLE);
      err_timeout <= abort;
      if (arm) begin
        idx <= '0;
      end else if (take && idx != LAST) begin
        idx <= idx + 1'b1;
      end
      if (commit_cap || commit_full) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGE; i++) begin
        cap[i]    <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (take) begin
        cap[idx] <= data;
      end
      if (commit_full) begin
        for (int i = 0; i < STAGE; i++) begin
          data_q[i] <= cap[i];
        end
      end else if (commit_cap) begin
        for (int i = 0; i < STAGE - 1; i++) begin
          data_q[i] <= cap[i];
        end
        data_q[STAGE-1] <= data;
      end
    end
  end

endmodule

// File: tb/tb_data_frame_latch.sv
// tb_data_frame_latch: scoreboard bench with a frame-level reference model
// of data_frame_latch (directed cases plus randomized gaps and backpressure).
`timescale 1ns/1ps
module tb_data_frame_latch;

  localparam int STAGE   = 8;
  localparam int DWIDTH  = 8;
  localparam int TIMEOUT = 4;
  localparam int FW      = STAGE * DWIDTH;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [DWIDTH-1:0] data = '0;
  logic [DWIDTH-1:0] data_q [0:STAGE-1];
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              frame_done;
  logic              busy;
  logic              err_overrun;
  logic              err_timeout;

  data_frame_latch #(
    .STAGE  (STAGE),
    .DWIDTH (DWIDTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .data       (data),
    .data_q     (data_q),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_done (frame_done),
    .busy       (busy),
    .err_overrun(err_overrun),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int t_start = 0;

  logic [FW-1:0] exp_q [$];
  logic [FW-1:0] dq_m = '0;
  logic          ov_m = 1'b0;
  logic          cons_prev = 1'b0;
  logic          ovr_drv = 1'b0;
  logic          ovr_prev = 1'b0;
  bit            tmo_ok = 1'b0;
  bit            rdy_rand = 1'b0;

  always @(posedge clk) cyc++;

  function automatic logic [FW-1:0] pack_q();
    logic [FW-1:0] v;
    for (int i = 0; i < STAGE; i++) v[i*DWIDTH +: DWIDTH] = data_q[i];
    return v;
  endfunction

  function automatic logic [FW-1:0] rnd_frame();
    logic [FW-1:0] f;
    for (int i = 0; i < STAGE; i++) f[i*DWIDTH +: DWIDTH] = DWIDTH'($urandom);
    return f;
  endfunction

  task automatic check(input string name, input logic [FW-1:0] act,
                       input logic [FW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: frames leave in capture order; out_valid and data_q follow
  // the handshake rules; err_overrun echoes a start issued mid-capture.
  always @(negedge clk) begin
    if (rst) begin
      dq_m      = '0;
      ov_m      = 1'b0;
      cons_prev = 1'b0;
      ovr_prev  = 1'b0;
    end else begin
      if (frame_done) begin
        if (exp_q.size() == 0) check("frame_done_spurious", 1, 0);
        else dq_m = exp_q.pop_front();
        ov_m = 1'b1;
      end else if (cons_prev) begin
        ov_m = 1'b0;
      end
      check("data_q", pack_q(), dq_m);
      check("out_valid", out_valid, ov_m);
      check("err_overrun", err_overrun, ovr_prev);
      if (!tmo_ok) check("err_timeout", err_timeout, 0);
      cons_prev = ov_m && out_ready;
      ovr_prev  = ovr_drv;
    end
  end

  initial forever begin
    step();
    if (rdy_rand) out_ready = 1'($urandom_range(1));
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin
      step();
      n++;
    end
    if (busy) check("wait_idle_bound", busy, 0);
  endtask

  // gmode: 0 no gaps, 1 word every other cycle, 2 random gaps (runs <= 2)
  task automatic send_frame(input logic [FW-1:0] f, input int gmode,
                            input int ovr_cyc, input int ovr_pct);
    int w = 0;
    int c = 0;
    int run = 0;
    bit v;
    wait_idle();
    start    = 1'b1;
    in_valid = 1'b0;
    data     = DWIDTH'($urandom);
    ovr_drv  = 1'b0;
    t_start  = cyc;
    step();
    while (w < STAGE) begin
      c++;
      case (gmode)
        1: v = c[0];
        2: v = (run >= 2) || ($urandom_range(99) >= 30);
        default: v = 1'b1;
      endcase
      in_valid = v;
      if (v) begin
        data = f[w*DWIDTH +: DWIDTH];
        w++;
        run = 0;
      end else begin
        data = DWIDTH'($urandom);
        run++;
      end
      start = (c == ovr_cyc) || (ovr_pct > 0 && $urandom_range(99) < ovr_pct);
      ovr_drv = start;
      if (w == STAGE) exp_q.push_back(f);
      step();
    end
    start    = 1'b0;
    in_valid = 1'b0;
    ovr_drv  = 1'b0;
  endtask

  task automatic expect_latency(input string name, input int lat);
    int n = 0;
    @(negedge clk);
    while (!frame_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, cyc - t_start, lat);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data_q"}, pack_q(), 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err_overrun"}, err_overrun, 0);
    check({tag, "_err_timeout"}, err_timeout, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [FW-1:0] f0, fa, fb, f3;
    for (int i = 0; i < STAGE; i++) f0[i*DWIDTH +: DWIDTH] = DWIDTH'(16 + i);

    repeat (3) step();
    @(negedge clk);
    check_reset_outputs("rst");
    step();
    rst = 1'b0;
    step();

    // back-to-back latency
    send_frame(f0, 0, -1, 0);
    expect_latency("lat_b2b", STAGE + 1);
    check("busy_after_commit", busy, 0);
    step();
    @(negedge clk);
    check("frame_done_one_cycle", frame_done, 0);
    step();

    // alternate-cycle gaps
    send_frame(f0, 1, -1, 0);
    expect_latency("lat_gaps", 2 * STAGE);
    step();

    // backpressure: A pending, B parks in FULL
    out_ready = 1'b0;
    fa = rnd_frame();
    fb = rnd_frame();
    send_frame(fa, 0, -1, 0);
    expect_latency("lat_a", STAGE + 1);
    step();
    send_frame(fb, 0, -1, 0);
    repeat (3) step();
    @(negedge clk);
    check("full_busy", busy, 1);
    check("full_data_q_a", pack_q(), fa);
    step();
    out_ready = 1'b1;
    step();
    @(negedge clk);
    check("full_commit_done", frame_done, 1);
    check("full_commit_b", pack_q(), fb);
    check("full_commit_valid", out_valid, 1);
    step();
    step();

    // overrun at cycle 3
    fa = rnd_frame();
    send_frame(fa, 0, 3, 0);
    expect_latency("lat_overrun", STAGE + 1);
    step();

    // reset mid-capture after 5 words
    fb = rnd_frame();
    wait_idle();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      data = fb[i*DWIDTH +: DWIDTH];
      step();
    end
    rst = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_reset_outputs("midrst");
    step();
    rst = 1'b0;
    step();
    fa = rnd_frame();
    send_frame(fa, 0, -1, 0);
    expect_latency("lat_after_rst", STAGE + 1);
    check("after_rst_word0", pack_q() & FW'(8'hff), FW'(fa[DWIDTH-1:0]));
    step();
    step();

    // starved capture: 3 words then in_valid low
    f3 = rnd_frame();
    wait_idle();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      data = f3[i*DWIDTH +: DWIDTH];
      step();
    end
    in_valid = 1'b0;
`ifdef FRAME_TIMEOUT_EN
    tmo_ok = 1'b1;
    for (int g = 0; g < TIMEOUT; g++) begin
      @(negedge clk);
      check("tmo_wait_flag", err_timeout, 0);
      check("tmo_wait_busy", busy, 1);
      step();
    end
    @(negedge clk);
    check("tmo_pulse", err_timeout, 1);
    check("tmo_idle", busy, 0);
    check("tmo_keeps_q", pack_q(), fa);
    step();
    @(negedge clk);
    check("tmo_pulse_end", err_timeout, 0);
    tmo_ok = 1'b0;
    step();
`else
    repeat (20) step();
    @(negedge clk);
    check("no_tmo_busy", busy, 1);
    step();
    for (int i = 3; i < STAGE; i++) begin
      in_valid = 1'b1;
      data = f3[i*DWIDTH +: DWIDTH];
      if (i == STAGE - 1) exp_q.push_back(f3);
      step();
    end
    in_valid = 1'b0;
    wait_idle();
    step();
`endif

    // randomized traffic
    rdy_rand = 1'b1;
    for (int k = 0; k < 40; k++) begin
      send_frame(rnd_frame(), 2, -1, 8);
    end
    for (int n = 0; n < 500 && exp_q.size() > 0; n++) step();
    check("sb_drain", exp_q.size(), 0);
    rdy_rand = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_frame_latch.md
# data_frame_latch

Synchronous, parametrised successor to the start-triggered data latch. A `start` pulse arms capture of a frame of `STAGE` words of width `DWIDTH` from a gated input stream; completed frames are committed to a held parallel output bank with a valid/ready handshake. Capture and output are double-buffered, so a new frame can be collected while the previous one waits for the consumer. It sits between the serial sample source and the parallel processing stage; every flop runs on `clk`, with no derived clocks.

## Interface
- `STAGE`, 8, words per frame (≥2)
- `DWIDTH`, 8, bits per word
- `TIMEOUT`, 16, idle-cycle limit for the abort feature (≥1); ignored when the feature is compiled out
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  arms a frame capture; honoured only in IDLE
- `in_valid`  in  1  `data` holds a word to capture this cycle
- `data`  in  DWIDTH  input word
- `data_q`  out  DWIDTH × [0:STAGE-1]  committed frame; `data_q[i]` is the i-th captured word
- `out_valid`  out  1  `data_q` holds an unconsumed frame
- `out_ready`  in  1  consumer accepts the frame when `out_valid` is high
- `frame_done`  out  1  one-cycle pulse in the cycle after a frame is committed to `data_q`
- `busy`  out  1  state ≠ IDLE
- `err_overrun`  out  1  one-cycle pulse when `start` arrives outside IDLE
- `err_timeout`  out  1  one-cycle pulse on a capture abort (always 0 without the feature)

## Operation
- Storage: capture buffer `cap[0:STAGE-1]`, index `idx` ($clog2(STAGE) bits), output bank `data_q`.
- States:
  - IDLE: `start` → CAPTURE with `idx` = 0. The `start`-cycle `data` is never captured.
  - CAPTURE: on each cycle with `in_valid` = 1, `cap[idx]` ← `data` and `idx` increments. Cycles with `in_valid` = 0 hold all capture state.
  - Last word (`idx` = STAGE-1 with `in_valid` = 1): if `!out_valid || out_ready`, then `data_q` ← {`cap[0..STAGE-2]`, `data`}, `out_valid` ← 1, `frame_done` pulses, and the state goes to IDLE. Otherwise `cap[STAGE-1]` ← `data` and the state goes to FULL.
  - FULL: the frame is held in `cap`. When `out_ready` is high, `data_q` ← `cap`, `out_valid` stays 1, `frame_done` pulses, and the state goes to IDLE.
- Handshake: a frame is consumed on a cycle with `out_valid && out_ready`. `out_valid` falls the next cycle unless a new frame is committed in the same cycle, in which case `out_valid` stays 1 and `data_q` updates.
- `data_q` is stable while `out_valid` = 1 and no commit occurs. `data_q` keeps its last frame after consumption.
- A `start` in CAPTURE or FULL is ignored, pulses `err_overrun`, and leaves the frame in progress unaffected.
- A `start` in the same cycle as a commit-to-IDLE is ignored (the state is not IDLE yet) and pulses `err_overrun`.
- `idx` never wraps: it resets to 0 on entry to CAPTURE.

## Timing
- Reset (asynchronous, any state, including mid-frame): state IDLE, `idx` = 0, `cap` = 0, `data_q` = all 0. `out_valid`, `frame_done`, `busy`, `err_overrun`, `err_timeout` = 0. Any partial frame is discarded.
- Back-to-back latency: `start` in cycle 0 and `in_valid` high in cycles 1..STAGE → `data_q`, `out_valid` = 1 and `frame_done` visible in cycle STAGE+1.
- Blocked commit: the frame enters `data_q` in the cycle after the first cycle in FULL with `out_ready` = 1.
- Minimum frame period: STAGE+1 cycles (IDLE → CAPTURE costs the `start` cycle).
- `busy` is registered: high from cycle 1 after `start` until the cycle after the return to IDLE.

## Configuration
- `FRAME_TIMEOUT_EN` defined:
  - In CAPTURE, a counter tracks consecutive cycles with `in_valid` = 0 and clears on any `in_valid` = 1.
  - When the count reaches `TIMEOUT`, the state goes to IDLE, `err_timeout` pulses, the partial frame is discarded, and `data_q`/`out_valid` are unchanged.
  - FULL is never timed out.
- `FRAME_TIMEOUT_EN` undefined: CAPTURE waits indefinitely, `err_timeout` is tied to 0, and no counter is synthesised.

## Test plan
- STAGE=8, DWIDTH=8, `out_ready` = 1: `start` at cycle 0, `data` = 0x10..0x17 with `in_valid` high in cycles 1–8 → in cycle 9 `data_q[0..7]` = 0x10..0x17, `out_valid` = 1, `frame_done` = 1 for one cycle.
- Gaps: the same frame with `in_valid` low every other cycle → `data_q` is identical and commits in cycle 16.
- Backpressure: frame A is pending with `out_ready` = 0, frame B completes → FULL, `data_q` still holds A. Raising `out_ready` → the next cycle `data_q` = B, `out_valid` stays 1.
- Overrun: `start` pulsed at cycle 3 of a capture → `err_overrun` pulses at cycle 4, and the frame still completes with the correct words.
- Reset mid-capture after 5 words → all outputs 0. A fresh frame afterwards captures correctly from `data_q[0]`.
- With `FRAME_TIMEOUT_EN` and TIMEOUT=4: 3 words, then `in_valid` low for 4 cycles → `err_timeout` pulses, the state is IDLE, and `data_q` still holds the prior frame. Without the macro: the same stimulus leaves `busy` = 1 indefinitely.
